// File: rtl/seg_digit_scanner.sv
// seg_digit_scanner
//   Time-multiplexed scan driver for a multi-digit 7-segment display.
//   One 4-bit code is presented at a time on digit_code, together with the
//   matching anode select. A pending/active double buffer makes sure a new
//   value only takes effect at a frame boundary, so a frame never tears.
//
//   Optional feature, selected at build time with the macro
//   LEADING_ZERO_BLANK_EN: digits above the most-significant nonzero active
//   digit keep their anode off. Digit 0 is always shown. Scan timing is
//   unchanged. Without the macro every digit is driven.
//
//   Handshake: load is a single-cycle strobe with no back-pressure. A load
//   while busy overwrites the pending value (latest wins). busy stays high
//   from a load until that value has moved into the active buffer at a frame
//   boundary.
//
//   Output timing: every output is registered from the next-state values, so
//   it changes on the same clock edge as the scan position it describes.
module seg_digit_scanner #(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int GUARD_CYCLES     = 2,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  output logic                    busy,
  output logic [3:0]              digit_code,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD   = PW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  // Pattern that leaves every anode dark, whichever polarity is in use.
  localparam logic [NUM_DIGITS-1:0] SEL_OFF =
    (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  // Scan position and buffers.
  logic [PW-1:0] pre_q, pre_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] active_q, active_d;
  logic [DW-1:0] pending_q, pending_d;
  logic          busy_q, busy_d;

  // Registered-output next values.
  logic [3:0]            code_d;
  logic [NUM_DIGITS-1:0] sel_d;
  logic                  fs_d;

  logic                  tick;
  logic                  boundary;
  logic                  guard_done;
  logic [NUM_DIGITS-1:0] show;
  logic [NUM_DIGITS-1:0] sel_on;

  // Slot and frame timing: tick ends a digit slot; boundary ends a frame.
  always_comb begin
    tick     = (pre_q == PRE_MAX);
    boundary = tick && (idx_q == IDX_MAX);
    pre_d    = tick ? '0 : pre_q + PW'(1);
    idx_d    = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
  end

  // Double buffer: pending moves to active only at a frame boundary, using
  // the busy value from before the edge. A load on that same cycle still
  // lands in pending and keeps busy high.
  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    busy_d    = busy_q;
    if (boundary && busy_q) begin
      active_d = pending_q;
      busy_d   = 1'b0;
    end
    if (load) begin
      pending_d = digits_in;
      busy_d    = 1'b1;
    end
  end

  // Per-digit visibility mask; leading-zero suppression when enabled.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    int msd;
    msd = 0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (active_d[4*k +: 4] != 4'h0) begin
        msd = k;
      end
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      show[k] = (k <= msd);
    end
`else
    show = {NUM_DIGITS{1'b1}};
`endif
  end

  // Output next values for the scan position that becomes current on the edge.
  always_comb begin
    code_d     = 4'h0;
    guard_done = (pre_d >= GUARD);
    sel_on     = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        code_d    = active_d[4*k +: 4];
        sel_on[k] = guard_done && show[k];
      end
    end
    sel_d = (ANODE_ACTIVE_LOW != 0) ? ~sel_on : sel_on;
    fs_d  = boundary;
  end

  // State and output registers; asynchronous reset aborts the scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q       <= '0;
      idx_q       <= '0;
      active_q    <= '0;
      pending_q   <= '0;
      busy_q      <= 1'b0;
      digit_code  <= 4'h0;
      digit_sel   <= SEL_OFF;
      frame_start <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      busy_q      <= busy_d;
      digit_code  <= code_d;
      digit_sel   <= sel_d;
      frame_start <= fs_d;
    end
  end

  assign busy = busy_q;

endmodule
